// File: rtl/sys_array_pkg.sv
// sys_array_pkg: shared types and helpers for the systolic array fetcher.
//   state_t  - controller states (IDLE, LOAD, RUN, STORE, DONE)
//   data_t   - default signed operand type
//   acc_t    - default signed accumulator type (twice the operand width)
//   ceil_div - integer ceiling division used for tile counts
package sys_array_pkg;

  localparam int unsigned PKG_DATA_WIDTH = 8;

  typedef logic signed [PKG_DATA_WIDTH-1:0]   data_t;
  typedef logic signed [2*PKG_DATA_WIDTH-1:0] acc_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    STORE,
    DONE
  } state_t;

  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/systolic_array_fetcher_split_if.sv
// systolic_array_fetcher_split_if: operand/result bundle of the fetcher.
//   start_comp   - start request (level, edge-detected by the slave)
//   input_data_a - matrix A, ARRAY_A_W x ARRAY_A_L signed operands
//   weights      - matrix W, ARRAY_W_W x ARRAY_W_L signed operands
//   ready        - result complete and block idle
//   out_data     - matrix C, ARRAY_A_W x ARRAY_W_L signed results
// master drives operands/start; slave (the fetcher) drives ready/out_data.
interface systolic_array_fetcher_split_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_A_W  = 4,
  parameter int ARRAY_A_L  = 3,
  parameter int ARRAY_W_W  = 3,
  parameter int ARRAY_W_L  = 4
);
  logic                           start_comp;
  logic signed [DATA_WIDTH-1:0]   input_data_a [ARRAY_A_W][ARRAY_A_L];
  logic signed [DATA_WIDTH-1:0]   weights      [ARRAY_W_W][ARRAY_W_L];
  logic                           ready;
  logic signed [2*DATA_WIDTH-1:0] out_data     [ARRAY_A_W][ARRAY_W_L];

  modport master (output start_comp, input_data_a, weights, input ready, out_data);
  modport slave  (input start_comp, input_data_a, weights, output ready, out_data);
endinterface

// File: rtl/sys_array_pe.sv
// sys_array_pe: one output-stationary MAC cell.
//   clk, rst     - clock, async active-high reset
//   clr_i        - synchronous clear of accumulator and pass-through regs
//   en_i         - accumulate enable
//   a_i / a_o    - operand from the left, registered to the right
//   w_i / w_o    - weight from above, registered downward
//   acc_o        - wrapping signed accumulator
module sys_array_pe #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr_i,
  input  logic                           en_i,
  input  logic signed [DATA_WIDTH-1:0]   a_i,
  input  logic signed [DATA_WIDTH-1:0]   w_i,
  output logic signed [DATA_WIDTH-1:0]   a_o,
  output logic signed [DATA_WIDTH-1:0]   w_o,
  output logic signed [2*DATA_WIDTH-1:0] acc_o
);
  logic signed [DATA_WIDTH-1:0]   a_q, w_q;
  logic signed [2*DATA_WIDTH-1:0] acc_q, prod;
  logic signed [2*DATA_WIDTH-1:0] a_ext, w_ext;

  // Sign-extend first so the product truncates modulo 2^(2*DATA_WIDTH).
  assign a_ext = {{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i};
  assign w_ext = {{DATA_WIDTH{w_i[DATA_WIDTH-1]}}, w_i};
  assign prod  = a_ext * w_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      w_q   <= '0;
      acc_q <= '0;
    end else if (clr_i) begin
      a_q   <= '0;
      w_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q <= a_i;
      w_q <= w_i;
      if (en_i) acc_q <= acc_q + prod;
    end
  end

  assign a_o   = a_q;
  assign w_o   = w_q;
  assign acc_o = acc_q;
endmodule

// File: rtl/systolic_array_fetcher_split.sv
// systolic_array_fetcher_split: C = A x W on an ARRAY_W x ARRAY_L
// output-stationary systolic grid, tiling C when it exceeds the grid.
//   clk   - clock, rising edge
//   reset - async active-high reset
//   bus   - slave side: start_comp, input_data_a, weights in; ready, out_data out
module systolic_array_fetcher_split
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ARRAY_A_W     = 4,
  parameter int ARRAY_A_L     = 3,
  parameter int ARRAY_W_W     = 3,
  parameter int ARRAY_W_L     = 4,
  parameter int ARRAY_W       = 5,
  parameter int ARRAY_L       = 5,
  parameter int ARRAY_MAX_A_L = 5,
  parameter int OUT_SIZE      = 100
) (
  input  logic                           clk,
  input  logic                           reset,
  systolic_array_fetcher_split_if.slave  bus
);
  typedef logic signed [DATA_WIDTH-1:0]   dat_t;
  typedef logic signed [2*DATA_WIDTH-1:0] sum_t;

  localparam int unsigned TR_N    = ceil_div(ARRAY_A_W, ARRAY_W);
  localparam int unsigned TC_N    = ceil_div(ARRAY_W_L, ARRAY_L);
  localparam int unsigned RUN_LEN = ARRAY_A_L + ARRAY_W + ARRAY_L - 2;
  localparam logic [7:0]  TR_LAST  = 8'(TR_N - 1);
  localparam logic [7:0]  TC_LAST  = 8'(TC_N - 1);
  localparam logic [7:0]  RUN_LAST = 8'(RUN_LEN - 1);

  if (ARRAY_W_W != ARRAY_A_L) begin : g_chk_inner
    $error("ARRAY_W_W must equal ARRAY_A_L");
  end
  if (ARRAY_A_L > ARRAY_MAX_A_L) begin : g_chk_max
    $error("ARRAY_A_L exceeds ARRAY_MAX_A_L");
  end
  if (ARRAY_A_W * ARRAY_W_L > OUT_SIZE) begin : g_chk_out
    $error("result exceeds OUT_SIZE");
  end

  state_t     state_q, state_d;
  logic       start_q, accept, ready_q;
  logic [7:0] tr_q, tr_d, tc_q, tc_d, run_q, run_d;
  logic       pe_clr, pe_en;

  dat_t a_lat_q [ARRAY_A_W][ARRAY_A_L];
  dat_t w_lat_q [ARRAY_W_W][ARRAY_W_L];
  sum_t out_q   [ARRAY_A_W][ARRAY_W_L];

  dat_t a_feed [ARRAY_W];
  dat_t w_feed [ARRAY_L];
  dat_t a_out  [ARRAY_W][ARRAY_L];
  dat_t w_out  [ARRAY_W][ARRAY_L];
  sum_t acc    [ARRAY_W][ARRAY_L];

  assign accept = (state_q == IDLE) && bus.start_comp && !start_q;
  assign pe_clr = (state_q == LOAD);
  assign pe_en  = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    tr_d    = tr_q;
    tc_d    = tc_q;
    run_d   = run_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = LOAD;
        tr_d    = '0;
        tc_d    = '0;
      end
      LOAD: begin
        state_d = RUN;
        run_d   = '0;
      end
      RUN: begin
        run_d = run_q + 8'd1;
        if (run_q == RUN_LAST) state_d = STORE;
      end
      STORE: begin
        state_d = LOAD;
        if (tc_q == TC_LAST) begin
          tc_d = '0;
          if (tr_q == TR_LAST) state_d = DONE;
          else                 tr_d    = tr_q + 8'd1;
        end else begin
          tc_d = tc_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Skewed feed: PE row r sees A[k] at RUN cycle k+r, PE column c sees W[k]
  // at cycle k+c. Anything outside the matrix or the current tile stays 0.
  always_comb begin
    for (int unsigned r = 0; r < ARRAY_W; r++) begin
      a_feed[r] = '0;
      for (int unsigned i = 0; i < ARRAY_A_W; i++)
        for (int unsigned k = 0; k < ARRAY_A_L; k++)
          if (state_q == RUN && i == 32'(tr_q) * ARRAY_W + r && 32'(run_q) == k + r)
            a_feed[r] = a_lat_q[i][k];
    end
    for (int unsigned c = 0; c < ARRAY_L; c++) begin
      w_feed[c] = '0;
      for (int unsigned j = 0; j < ARRAY_W_L; j++)
        for (int unsigned k = 0; k < ARRAY_W_W; k++)
          if (state_q == RUN && j == 32'(tc_q) * ARRAY_L + c && 32'(run_q) == k + c)
            w_feed[c] = w_lat_q[k][j];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      ready_q <= 1'b0;
      tr_q    <= '0;
      tc_q    <= '0;
      run_q   <= '0;
      for (int unsigned i = 0; i < ARRAY_A_W; i++)
        for (int unsigned k = 0; k < ARRAY_A_L; k++) a_lat_q[i][k] <= '0;
      for (int unsigned k = 0; k < ARRAY_W_W; k++)
        for (int unsigned j = 0; j < ARRAY_W_L; j++) w_lat_q[k][j] <= '0;
      for (int unsigned i = 0; i < ARRAY_A_W; i++)
        for (int unsigned j = 0; j < ARRAY_W_L; j++) out_q[i][j] <= '0;
    end else begin
      state_q <= state_d;
      start_q <= bus.start_comp;
      tr_q    <= tr_d;
      tc_q    <= tc_d;
      run_q   <= run_d;
      if (accept) begin
        ready_q <= 1'b0;
        a_lat_q <= bus.input_data_a;
        w_lat_q <= bus.weights;
      end else if (state_q == DONE) begin
        ready_q <= 1'b1;
      end
      if (state_q == STORE)
        for (int unsigned i = 0; i < ARRAY_A_W; i++)
          for (int unsigned j = 0; j < ARRAY_W_L; j++)
            for (int unsigned r = 0; r < ARRAY_W; r++)
              for (int unsigned c = 0; c < ARRAY_L; c++)
                if (i == 32'(tr_q) * ARRAY_W + r && j == 32'(tc_q) * ARRAY_L + c)
                  out_q[i][j] <= acc[r][c];
    end
  end

  assign bus.ready    = ready_q;
  assign bus.out_data = out_q;

  for (genvar r = 0; r < ARRAY_W; r++) begin : g_row
    for (genvar c = 0; c < ARRAY_L; c++) begin : g_col
      dat_t a_in, w_in;
      if (c == 0) begin : g_a_edge
        assign a_in = a_feed[r];
      end else begin : g_a_mid
        assign a_in = a_out[r][c-1];
      end
      if (r == 0) begin : g_w_edge
        assign w_in = w_feed[c];
      end else begin : g_w_mid
        assign w_in = w_out[r-1][c];
      end
      sys_array_pe #(.DATA_WIDTH(DATA_WIDTH)) u_pe (
        .clk   (clk),
        .rst   (reset),
        .clr_i (pe_clr),
        .en_i  (pe_en),
        .a_i   (a_in),
        .w_i   (w_in),
        .a_o   (a_out[r][c]),
        .w_o   (w_out[r][c]),
        .acc_o (acc[r][c])
      );
    end
  end
endmodule

// File: tb/tb_systolic_array_fetcher_split.sv
module tb_systolic_array_fetcher_split;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int AL = 3;
  localparam int WL = 4;
  localparam int LAT_D = 14;  // 1 tile:  (1+11+1)*1+1
  localparam int LAT_S = 29;  // 4 tiles: (1+5+1)*4+1

  typedef logic signed [DW-1:0] amat_t [AW][AL];
  typedef logic signed [DW-1:0] wmat_t [AL][WL];
  typedef logic [AW*WL*16-1:0]  cflat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  systolic_array_fetcher_split_if #(.DATA_WIDTH(DW), .ARRAY_A_W(AW), .ARRAY_A_L(AL),
                                    .ARRAY_W_W(AL), .ARRAY_W_L(WL)) bus_d ();
  systolic_array_fetcher_split_if #(.DATA_WIDTH(DW), .ARRAY_A_W(AW), .ARRAY_A_L(AL),
                                    .ARRAY_W_W(AL), .ARRAY_W_L(WL)) bus_s ();

  systolic_array_fetcher_split #(.DATA_WIDTH(DW), .ARRAY_A_W(AW), .ARRAY_A_L(AL),
    .ARRAY_W_W(AL), .ARRAY_W_L(WL), .ARRAY_W(5), .ARRAY_L(5)) dut_d (
    .clk(clk), .reset(reset), .bus(bus_d));

  systolic_array_fetcher_split #(.DATA_WIDTH(DW), .ARRAY_A_W(AW), .ARRAY_A_L(AL),
    .ARRAY_W_W(AL), .ARRAY_W_L(WL), .ARRAY_W(2), .ARRAY_L(2)) dut_s (
    .clk(clk), .reset(reset), .bus(bus_s));

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  cflat_t      qexp_d[$], qexp_s[$];
  int unsigned qdue_d[$], qdue_s[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Reference: plain matrix product, wrapped to 16 bits.
  function automatic cflat_t ref_mm(input amat_t a, input wmat_t w);
    cflat_t res = '0;
    for (int i = 0; i < AW; i++)
      for (int j = 0; j < WL; j++) begin
        int s = 0;
        for (int k = 0; k < AL; k++) s += int'(a[i][k]) * int'(w[k][j]);
        res[(i*WL+j)*16 +: 16] = s[15:0];
      end
    return res;
  endfunction

  task automatic compare_result(input string tag, input cflat_t e, input int unsigned due,
                                input logic signed [15:0] act [AW][WL]);
    check($sformatf("%s latency", tag), cyc, due);
    for (int i = 0; i < AW; i++)
      for (int j = 0; j < WL; j++) begin
        logic signed [15:0] ev;
        ev = e[(i*WL+j)*16 +: 16];
        check($sformatf("%s C[%0d][%0d]", tag, i, j), act[i][j], ev);
      end
  endtask

  // Monitors: a rising ready pops one expectation per DUT.
  logic prev_d = 1'b0, prev_s = 1'b0;
  always @(negedge clk) begin
    if (bus_d.ready && !prev_d) begin
      if (qexp_d.size() == 0) check("dflt unexpected_ready", 1, 0);
      else compare_result("dflt", qexp_d.pop_front(), qdue_d.pop_front(), bus_d.out_data);
    end
    prev_d = bus_d.ready;
  end
  always @(negedge clk) begin
    if (bus_s.ready && !prev_s) begin
      if (qexp_s.size() == 0) check("split unexpected_ready", 1, 0);
      else compare_result("split", qexp_s.pop_front(), qdue_s.pop_front(), bus_s.out_data);
    end
    prev_s = bus_s.ready;
  end

  task automatic drive(input amat_t a, input wmat_t w);
    bus_d.input_data_a = a; bus_s.input_data_a = a;
    bus_d.weights      = w; bus_s.weights      = w;
  endtask

  function automatic amat_t rand_a();
    amat_t a;
    for (int i = 0; i < AW; i++) for (int k = 0; k < AL; k++) a[i][k] = 8'($urandom);
    return a;
  endfunction

  function automatic wmat_t rand_w();
    wmat_t w;
    for (int k = 0; k < AL; k++) for (int j = 0; j < WL; j++) w[k][j] = 8'($urandom);
    return w;
  endfunction

  task automatic set_start(input logic v);
    bus_d.start_comp = v;
    bus_s.start_comp = v;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (qexp_d.size() != 0 || qexp_s.size() != 0); i++)
      @(negedge clk);
    if (qexp_d.size() != 0 || qexp_s.size() != 0) begin
      check("ready timeout", qexp_d.size() + qexp_s.size(), 0);
      qexp_d.delete(); qdue_d.delete(); qexp_s.delete(); qdue_s.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Issue a start edge, push expectations, scramble inputs a cycle later.
  task automatic launch(input amat_t a, input wmat_t w, input bit hold);
    cflat_t e;
    int unsigned acc_c;
    @(negedge clk);
    drive(a, w);
    set_start(1'b1);
    acc_c = cyc + 1;
    e = ref_mm(a, w);
    qexp_d.push_back(e); qdue_d.push_back(acc_c + LAT_D);
    qexp_s.push_back(e); qdue_s.push_back(acc_c + LAT_S);
    @(negedge clk);
    drive(rand_a(), rand_w());
    if (hold) begin
      repeat (5) @(negedge clk);
      set_start(1'b0);
      @(negedge clk);
      set_start(1'b1);  // rising edge while busy
      @(negedge clk);
    end
    set_start(1'b0);
  endtask

  task automatic check_cleared(input string tag);
    check($sformatf("%s dflt ready", tag), bus_d.ready, 0);
    check($sformatf("%s split ready", tag), bus_s.ready, 0);
    for (int i = 0; i < AW; i++)
      for (int j = 0; j < WL; j++) begin
        check($sformatf("%s dflt C[%0d][%0d]", tag, i, j), bus_d.out_data[i][j], 0);
        check($sformatf("%s split C[%0d][%0d]", tag, i, j), bus_s.out_data[i][j], 0);
      end
  endtask

  initial begin
    amat_t a_basic, a_min;
    wmat_t w_basic, w_min;
    a_basic = '{'{8'sd1, 8'sd2, 8'sd3}, '{8'sd4, 8'sd5, 8'sd6},
                '{8'sd7, 8'sd8, 8'sd9}, '{8'sd10, 8'sd11, 8'sd12}};
    w_basic = '{'{8'sd1, 8'sd0, 8'sd0, 8'sd1}, '{8'sd0, 8'sd1, 8'sd0, 8'sd1},
                '{8'sd0, 8'sd0, 8'sd1, 8'sd1}};
    for (int i = 0; i < AW; i++) for (int k = 0; k < AL; k++) a_min[i][k] = -8'sd128;
    for (int k = 0; k < AL; k++) for (int j = 0; j < WL; j++) w_min[k][j] = -8'sd128;

    set_start(1'b0);
    drive(a_basic, w_basic);
    repeat (3) @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    launch(a_basic, w_basic, 1'b0);
    wait_idle();
    launch(a_min, w_min, 1'b0);
    wait_idle();
    launch(a_basic, w_basic, 1'b1);
    wait_idle();

    // Reset mid-RUN aborts both DUTs and drops their pending results.
    launch(rand_a(), rand_w(), 1'b0);
    repeat (5) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check_cleared("midreset");
    qexp_d.delete(); qdue_d.delete(); qexp_s.delete(); qdue_s.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    launch(a_basic, w_basic, 1'b0);
    wait_idle();

    for (int n = 0; n < 6; n++) begin
      launch(rand_a(), rand_w(), 1'b0);
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
